// File: rtl/escritor_bloques.sv
// Frame loader: accepts a raster-order pixel stream and writes each pixel to the
// block-tiled memory address used by the VGA read path, one registered write per pixel.
module escritor_bloques #(
    parameter int N      = 18,
    parameter int DATA_W = 8,
    parameter int BLK    = 100,
    parameter int BLK_N  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              we,
    output logic [N-1:0]      addr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done
);

    localparam int LW = $clog2(BLK);
    localparam int BW = $clog2(BLK_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     lx_q, lx_d, ly_q, ly_d;
    logic [BW-1:0]     bx_q, bx_d, by_q, by_d;
    logic              we_q, we_d;
    logic [N-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic accept;
    logic lx_wrap, bx_wrap, ly_wrap, by_wrap, last_px;

    always_comb begin
        accept  = in_valid && (state_q == S_LOAD);
        lx_wrap = (lx_q == LW'(BLK - 1));
        bx_wrap = (bx_q == BW'(BLK_N - 1));
        ly_wrap = (ly_q == LW'(BLK - 1));
        by_wrap = (by_q == BW'(BLK_N - 1));
        last_px = lx_wrap && bx_wrap && ly_wrap && by_wrap;
    end

    always_comb begin
        state_d = state_q;
        lx_d    = lx_q;
        bx_d    = bx_q;
        ly_d    = ly_q;
        by_d    = by_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    lx_d    = '0;
                    bx_d    = '0;
                    ly_d    = '0;
                    by_d    = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    // Tile index selects the 10000-word block, then raster order inside it.
                    addr_d  = N'((int'(by_q) * BLK_N + int'(bx_q)) * BLK * BLK
                                 + int'(ly_q) * BLK + int'(lx_q));
                    wdata_d = in_data;
                    if (last_px) begin
                        state_d = S_DONE;
                        lx_d    = '0;
                        bx_d    = '0;
                        ly_d    = '0;
                        by_d    = '0;
                    end else if (!lx_wrap) begin
                        lx_d = lx_q + 1'b1;
                    end else begin
                        lx_d = '0;
                        if (!bx_wrap) begin
                            bx_d = bx_q + 1'b1;
                        end else begin
                            bx_d = '0;
                            if (!ly_wrap) begin
                                ly_d = ly_q + 1'b1;
                            end else begin
                                ly_d = '0;
                                by_d = by_q + 1'b1;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lx_q    <= '0;
            bx_q    <= '0;
            ly_q    <= '0;
            by_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            lx_q    <= lx_d;
            bx_q    <= bx_d;
            ly_q    <= ly_d;
            by_q    <= by_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Handshake and status come straight from the state register, never from in_valid.
    assign in_ready = (state_q == S_LOAD);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign we       = we_q;
    assign addr     = addr_q;
    assign wdata    = wdata_q;

endmodule

// File: tb/tb_escritor_bloques.sv
// Randomized scoreboard bench for escritor_bloques on a reduced 80x80 image (4x4 blocks of 20x20).
module tb_escritor_bloques;

    localparam int N      = 18;
    localparam int DATA_W = 8;
    localparam int BLK    = 20;
    localparam int BLK_N  = 4;
    localparam int SIDE   = BLK * BLK_N;
    localparam int FRAME  = SIDE * SIDE;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              we;
    logic [N-1:0]      addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;

    escritor_bloques #(.N(N), .DATA_W(DATA_W), .BLK(BLK), .BLK_N(BLK_N)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .addr(addr), .wdata(wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc = 0;
    int unsigned exp_done_cyc = 0;
    int          tests = 0;
    int          failed = 0;
    int          writes = 0;
    int          done_cnt = 0;
    int          hit[FRAME];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference mapping from raster position, written with plain division.
    function automatic int unsigned tiled(input int r, input int c);
        return ((r / BLK) * BLK_N + c / BLK) * BLK * BLK + (r % BLK) * BLK + (c % BLK);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every write the DUT presents.
    always @(negedge clk) begin
        exp_t e;
        if (we === 1'b1) begin
            writes++;
            if (sb_q.size() == 0) begin
                chk("unexpected_write_addr", 32'(addr), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("write_addr", 32'(addr), e.addr);
                chk("write_data", 32'(wdata), e.data);
                chk("write_cycle", cyc, e.cyc);
                $display("[TB] write addr=%0d data=%02h cycle=%0d", addr, wdata, cyc);
            end
            if (int'(addr) < FRAME) hit[addr]++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_cycle", cyc, exp_done_cyc);
        end
    end

    task automatic run_frame(input int gap_pct, input int abort_after, input bit start_mid,
                             input bit start_last, input bit start_done, input bit first_a5);
        int   px = 0;
        int   guard = 0;
        int   limit;
        int   bad = 0;
        bit   v;
        logic [DATA_W-1:0] d;
        exp_t e;
        limit = (abort_after > 0) ? abort_after : FRAME;
        writes   = 0;
        done_cnt = 0;
        foreach (hit[i]) hit[i] = 0;

        // A pixel presented in the start cycle itself must not be written.
        start    = 1'b1;
        in_valid = 1'($urandom_range(1));
        in_data  = DATA_W'($urandom);
        step();
        start = 1'b0;
        chk("ready_after_start", 32'(in_ready), 1);
        chk("busy_after_start", 32'(busy), 1);

        while (px < limit && guard < 8 * FRAME) begin
            guard++;
            v        = ($urandom_range(99) >= gap_pct);
            d        = (first_a5 && px == 0) ? 8'hA5 : DATA_W'($urandom);
            in_valid = v;
            in_data  = d;
            start    = (start_mid && px == limit / 2) || (start_last && v && px == FRAME - 1);
            if (v) begin
                e.addr = tiled(px / SIDE, px % SIDE);
                e.data = 32'(d);
                e.cyc  = cyc + 1;
                sb_q.push_back(e);
                if (px == FRAME - 1) exp_done_cyc = cyc + 1;
                px++;
            end
            step();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("pixels_issued", px, limit);

        if (abort_after == 0) begin
            chk("done_pulse", 32'(done), 1);
            chk("ready_in_done", 32'(in_ready), 0);
            chk("busy_in_done", 32'(busy), 1);
            start = start_done;
            step();
            start = 1'b0;
            chk("done_low", 32'(done), 0);
            chk("busy_idle", 32'(busy), 0);
            chk("ready_idle", 32'(in_ready), 0);
            step();
            step();
            chk("we_idle", 32'(we), 0);
            chk("frame_writes", writes, FRAME);
            chk("scoreboard_empty", sb_q.size(), 0);
            chk("done_count", done_cnt, 1);
            foreach (hit[i]) if (hit[i] != 1) bad++;
            chk("addr_coverage_bad", bad, 0);
            $display("[TB] frame complete: writes=%0d cycle=%0d", writes, cyc);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'($urandom_range(1));
        in_valid = 1'($urandom_range(1));
        in_data  = DATA_W'($urandom);
        step();
        start    = 1'($urandom_range(1));
        in_valid = 1'($urandom_range(1));
        in_data  = DATA_W'($urandom);
        step();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        step();

        // Gapped frame, starting with 0xA5, start pulsed mid-load and during DONE.
        run_frame(25, 0, 1'b1, 1'b0, 1'b1, 1'b1);
        // Back-to-back frame with start coinciding with the last accept.
        run_frame(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        // Partial frame then reset (with a simultaneous start that reset must override).
        run_frame(0, 500, 1'b1, 1'b0, 1'b0, 1'b0);
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("midrst_we", 32'(we), 0);
        chk("midrst_addr", 32'(addr), 0);
        chk("midrst_wdata", 32'(wdata), 0);
        chk("midrst_ready", 32'(in_ready), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_sb_empty", sb_q.size(), 0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom);
            step();
            chk("idle_no_ready", 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        step();
        // Fresh frame after the abort must begin at address 0.
        run_frame(10, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
